mem_access_stage: RTL

Pipeline stage directly downstream of merge_execution. It registers execution results for writeback and owns the DMEM req/ack handshake for LOAD/STORE. The upstream stage is stalled via ready_o until each memory transaction completes or times out. It drives the register-file writeback interface.

---
 rtl/mem_access_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: retires ALU results directly and runs the DMEM
// req/ack handshake (with optional timeout) for LOAD/STORE before writeback.

package simple_processor_pkg;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      FUNC_NOP   = 4'd0,
      FUNC_ADD   = 4'd1,
      FUNC_SUB   = 4'd2,
      FUNC_AND   = 4'd3,
      FUNC_OR    = 4'd4,
      FUNC_XOR   = 4'd5,
      FUNC_SLL   = 4'd6,
      FUNC_SRL   = 4'd7,
      FUNC_LOAD  = 4'd8,
      FUNC_STORE = 4'd9
   } func_t;
endpackage

// state    | meaning
// IDLE     | accepting; non-memory ops retire on the next cycle
// WAIT_ACK | DMEM request outstanding, upstream stalled
module mem_access_stage
   import simple_processor_pkg::*;
#(
   parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
   parameter int RF_ADDR_W      = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  func_t                 func_i,
   input  logic [DATA_WIDTH-1:0] result_i,
   input  logic [DATA_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [RF_ADDR_W-1:0]  rd_addr_i,
   output logic                  dmem_req_o,
   output logic [DATA_WIDTH-1:0] dmem_addr_o,
   output logic                  dmem_we_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
   input  logic                  dmem_ack_i,
   output logic                  wb_valid_o,
   output logic                  wb_we_o,
   output logic [RF_ADDR_W-1:0]  wb_rd_addr_o,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic                  err_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t                state_q, state_nxt;
   logic [CNT_W-1:0]      cnt_q, cnt_nxt;
   logic [RF_ADDR_W-1:0]  rd_q, rd_nxt;
   logic                  req_nxt, we_nxt, wb_valid_nxt, wb_we_nxt, err_nxt;
   logic [DATA_WIDTH-1:0] addr_nxt, wdata_nxt, wb_data_nxt;
   logic [RF_ADDR_W-1:0]  wb_rd_nxt;
   logic                  is_mem, timed_out;

   assign is_mem    = (func_i == FUNC_LOAD) || (func_i == FUNC_STORE);
   assign timed_out = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);
   assign ready_o   = (state_q == IDLE);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         rd_q         <= '0;
         dmem_req_o   <= 1'b0;
         dmem_addr_o  <= '0;
         dmem_we_o    <= 1'b0;
         dmem_wdata_o <= '0;
         wb_valid_o   <= 1'b0;
         wb_we_o      <= 1'b0;
         wb_rd_addr_o <= '0;
         wb_data_o    <= '0;
         err_o        <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         cnt_q        <= cnt_nxt;
         rd_q         <= rd_nxt;
         dmem_req_o   <= req_nxt;
         dmem_addr_o  <= addr_nxt;
         dmem_we_o    <= we_nxt;
         dmem_wdata_o <= wdata_nxt;
         wb_valid_o   <= wb_valid_nxt;
         wb_we_o      <= wb_we_nxt;
         wb_rd_addr_o <= wb_rd_nxt;
         wb_data_o    <= wb_data_nxt;
         err_o        <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      cnt_nxt      = cnt_q;
      rd_nxt       = rd_q;
      req_nxt      = dmem_req_o;
      addr_nxt     = dmem_addr_o;
      we_nxt       = dmem_we_o;
      wdata_nxt    = dmem_wdata_o;
      wb_valid_nxt = 1'b0;
      wb_we_nxt    = 1'b0;
      wb_rd_nxt    = wb_rd_addr_o;
      wb_data_nxt  = wb_data_o;
      err_nxt      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (is_mem) begin
                  state_nxt = WAIT_ACK;
                  cnt_nxt   = '0;
                  rd_nxt    = rd_addr_i;
                  req_nxt   = 1'b1;
                  addr_nxt  = addr_i;
                  we_nxt    = (func_i == FUNC_STORE);
                  wdata_nxt = wdata_i;
               end else begin
                  wb_valid_nxt = 1'b1;
                  wb_we_nxt    = 1'b1;
                  wb_rd_nxt    = rd_addr_i;
                  wb_data_nxt  = result_i;
               end
            end
         end
         WAIT_ACK: begin
            // ack beats a timeout landing on the same edge
            if (dmem_ack_i) begin
               state_nxt    = IDLE;
               req_nxt      = 1'b0;
               wb_valid_nxt = 1'b1;
               wb_we_nxt    = !dmem_we_o;
               wb_rd_nxt    = rd_q;
               wb_data_nxt  = dmem_we_o ? '0 : dmem_rdata_i;
            end else if (timed_out) begin
               state_nxt    = IDLE;
               req_nxt      = 1'b0;
               wb_valid_nxt = 1'b1;
               wb_rd_nxt    = rd_q;
               wb_data_nxt  = '0;
               err_nxt      = 1'b1;
            end else if (TIMEOUT_CYCLES > 0) begin
               cnt_nxt = cnt_q + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
